// File: rtl/layer_reg_ctrl_if.sv
// Bus bundle for layer_reg_ctrl: both write ports, register-file
// side and the scan output stream, with slave (DUT) and master views.
interface layer_reg_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int POS_W  = 4
);
    logic              w0_valid_i;
    logic              w0_ready_o;
    logic [4:0]        w0_addr_i;
    logic [DATA_W-1:0] w0_data_i;
    logic [POS_W-1:0]  w0_pos_i;
    logic              w1_valid_i;
    logic              w1_ready_o;
    logic [4:0]        w1_addr_i;
    logic [DATA_W-1:0] w1_data_i;
    logic [POS_W-1:0]  w1_pos_i;
    logic              rf_we_o;
    logic [4:0]        rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic [POS_W-1:0]  rf_pos_o;
    logic [4:0]        rf_op_addr_o;
    logic [DATA_W-1:0] rf_reg_i;
    logic [POS_W-1:0]  rf_pos_i;
    logic              scan_start_i;
    logic              scan_busy_o;
    logic              scan_done_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [4:0]        out_addr_o;
    logic [DATA_W-1:0] out_data_o;
    logic [POS_W-1:0]  out_pos_o;

    modport slave (
        input  w0_valid_i, w0_addr_i, w0_data_i, w0_pos_i,
        input  w1_valid_i, w1_addr_i, w1_data_i, w1_pos_i,
        output w0_ready_o, w1_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, rf_pos_o,
        output rf_op_addr_o,
        input  rf_reg_i, rf_pos_i,
        input  scan_start_i, out_ready_i,
        output scan_busy_o, scan_done_o,
        output out_valid_o, out_addr_o, out_data_o, out_pos_o
    );

    modport master (
        output w0_valid_i, w0_addr_i, w0_data_i, w0_pos_i,
        output w1_valid_i, w1_addr_i, w1_data_i, w1_pos_i,
        input  w0_ready_o, w1_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, rf_pos_o,
        input  rf_op_addr_o,
        output rf_reg_i, rf_pos_i,
        output scan_start_i, out_ready_i,
        input  scan_busy_o, scan_done_o,
        input  out_valid_o, out_addr_o, out_data_o, out_pos_o
    );
endinterface

// File: rtl/layer_reg_ctrl.sv
// Round-robin write arbiter and scan sequencer for the layer register file.
// LAYER_REG_SKIP_EMPTY_EN: skip entries whose pos tag is zero during a scan.
module layer_reg_ctrl #(
    parameter int DATA_W    = 32,
    parameter int POS_W     = 4,
    parameter int LAST_ADDR = 31
) (
    input  logic             clk_i,
    input  logic             reset_n,
    layer_reg_ctrl_if.slave  bus
);
    localparam logic [4:0] LAST_A = 5'(LAST_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        HOLD,
        DONE
    } state_t;

    logic              r_last;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [POS_W-1:0]  r_rf_pos;

    logic              w_g0;
    logic              w_g1;

    state_t            r_state;
    state_t            w_next;
    logic [4:0]        r_op_addr;
    logic              r_out_valid;
    logic [4:0]        r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic [POS_W-1:0]  r_out_pos;

    logic              w_hs;
    logic              w_at_last;
    logic              w_empty;

    // r_last names the port granted most recently; the other one wins ties
    assign w_g0 = bus.w0_valid_i & (~bus.w1_valid_i | r_last);
    assign w_g1 = bus.w1_valid_i & (~bus.w0_valid_i | ~r_last);

    assign bus.w0_ready_o = w_g0;
    assign bus.w1_ready_o = w_g1;

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_last     <= 1'b1;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_rf_pos   <= '0;
        end else begin
            r_rf_we <= w_g0 | w_g1;
            if (w_g0) begin
                r_last     <= 1'b0;
                r_rf_waddr <= bus.w0_addr_i;
                r_rf_wdata <= bus.w0_data_i;
                r_rf_pos   <= bus.w0_pos_i;
            end else if (w_g1) begin
                r_last     <= 1'b1;
                r_rf_waddr <= bus.w1_addr_i;
                r_rf_wdata <= bus.w1_data_i;
                r_rf_pos   <= bus.w1_pos_i;
            end
        end
    end

    assign bus.rf_we_o    = r_rf_we;
    assign bus.rf_waddr_o = r_rf_waddr;
    assign bus.rf_wdata_o = r_rf_wdata;
    assign bus.rf_pos_o   = r_rf_pos;

`ifdef LAYER_REG_SKIP_EMPTY_EN
    assign w_empty = (bus.rf_pos_i == '0);
`else
    assign w_empty = 1'b0;
`endif

    assign w_hs      = r_out_valid & bus.out_ready_i;
    assign w_at_last = (r_op_addr == LAST_A);

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (bus.scan_start_i) w_next = CAPT;
            CAPT: begin
                if (!w_empty) w_next = HOLD;
                else if (w_at_last) w_next = DONE;
            end
            HOLD: begin
                if (w_hs) w_next = w_at_last ? DONE : CAPT;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_op_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_pos   <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (bus.scan_start_i) r_op_addr <= '0;
                CAPT: begin
                    if (w_empty) begin
                        if (!w_at_last) r_op_addr <= r_op_addr + 5'd1;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_out_addr  <= r_op_addr;
                        r_out_data  <= bus.rf_reg_i;
                        r_out_pos   <= bus.rf_pos_i;
                    end
                end
                HOLD: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        if (!w_at_last) r_op_addr <= r_op_addr + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rf_op_addr_o = r_op_addr;
    assign bus.scan_busy_o  = (r_state != IDLE);
    assign bus.scan_done_o  = (r_state == DONE);
    assign bus.out_valid_o  = r_out_valid;
    assign bus.out_addr_o   = r_out_addr;
    assign bus.out_data_o   = r_out_data;
    assign bus.out_pos_o    = r_out_pos;
endmodule

// File: tb/tb_layer_reg_ctrl.sv
// Scoreboard bench for layer_reg_ctrl: random writes and scans checked
// against a queue-based model of the register file and arbitration rules.
module tb_layer_reg_ctrl;
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  p;
    } beat_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   beat_cnt = 0;
    int   start_cyc = 0;
    int   exp_lat = 0;
    bit   scanning = 0;
    bit   m_last = 1;

    logic [31:0] rf_d [32];
    logic [3:0]  rf_p [32];
    logic [31:0] m_d [32];
    logic [3:0]  m_p [32];

    beat_t wq[$];
    beat_t bq[$];

    layer_reg_ctrl_if #(.DATA_W(32), .POS_W(4)) bus();

    layer_reg_ctrl #(
        .DATA_W(32), .POS_W(4), .LAST_ADDR(31)
    ) dut (
        .clk_i  (clk),
        .reset_n(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_d[i] = '0;
            rf_p[i] = '0;
            m_d[i]  = '0;
            m_p[i]  = '0;
        end
    end

    // register file itself: commits on the falling edge
    always @(negedge clk) begin
        if (bus.rf_we_o) begin
            rf_d[bus.rf_waddr_o] <= bus.rf_wdata_o;
            rf_p[bus.rf_waddr_o] <= bus.rf_pos_o;
        end
    end
    assign bus.rf_reg_i = rf_d[bus.rf_op_addr_o];
    assign bus.rf_pos_i = rf_p[bus.rf_op_addr_o];

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        beat_t e;
        if (bus.rf_we_o) begin
            if (wq.size() == 0) begin
                chk("rf_we_spurious", 64'(bus.rf_we_o), 0);
            end else begin
                e = wq.pop_front();
                chk("rf_write",
                    {bus.rf_waddr_o, bus.rf_wdata_o, bus.rf_pos_o},
                    {e.a, e.d, e.p});
            end
        end
        if (bus.out_valid_o) begin
            if (bq.size() == 0) begin
                chk("beat_spurious", 64'(bus.out_valid_o), 0);
            end else begin
                e = bq[0];
                chk("beat",
                    {bus.out_addr_o, bus.out_data_o, bus.out_pos_o},
                    {e.a, e.d, e.p});
                if (bus.out_ready_i) begin
                    void'(bq.pop_front());
                    beat_cnt++;
                end
            end
        end
        if (bus.scan_done_o) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", 64'(bus.scan_busy_o), 1);
        end
    end

    // expected scan contents and unstalled cost: 2 per shown entry, 1 per skip
    task automatic push_beats();
        beat_t b;
        exp_lat = 0;
        for (int i = 0; i < 32; i++) begin
`ifdef LAYER_REG_SKIP_EMPTY_EN
            if (m_p[i] == 4'd0) begin
                exp_lat += 1;
                continue;
            end
`endif
            b.a = 5'(i);
            b.d = m_d[i];
            b.p = m_p[i];
            bq.push_back(b);
            exp_lat += 2;
        end
    endtask

    task automatic step();
        logic  g0, g1;
        beat_t w;
        #2;
        g0 = bus.w0_valid_i && (!bus.w1_valid_i || m_last);
        g1 = bus.w1_valid_i && (!bus.w0_valid_i || !m_last);
        chk("grant", {bus.w0_ready_o, bus.w1_ready_o}, {g0, g1});
        @(posedge clk);
        #1;
        if (g0) begin
            w = '{bus.w0_addr_i, bus.w0_data_i, bus.w0_pos_i};
            m_last = 0;
        end else if (g1) begin
            w = '{bus.w1_addr_i, bus.w1_data_i, bus.w1_pos_i};
            m_last = 1;
        end
        if (g0 || g1) begin
            wq.push_back(w);
            m_d[w.a] = w.d;
            m_p[w.a] = w.p;
        end
        if (bus.scan_start_i && !scanning) begin
            scanning  = 1;
            start_cyc = cyc;
            push_beats();
        end
        bus.w0_valid_i   = 0;
        bus.w1_valid_i   = 0;
        bus.scan_start_i = 0;
    endtask

    task automatic do_reset();
        rst_n            = 0;
        bus.w0_valid_i   = 0;
        bus.w1_valid_i   = 0;
        bus.scan_start_i = 0;
        bus.out_ready_i  = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        wq.delete();
        bq.delete();
        scanning = 0;
        m_last   = 1;
        chk("reset_rf", {bus.rf_we_o, bus.rf_waddr_o,
                         bus.rf_wdata_o, bus.rf_pos_o}, 0);
        chk("reset_scan", {bus.rf_op_addr_o, bus.out_valid_o,
                           bus.out_addr_o, bus.out_pos_o,
                           bus.scan_busy_o, bus.scan_done_o}, 0);
        chk("reset_odata", bus.out_data_o, 0);
    endtask

    task automatic wr(input bit port, input int a,
                      input logic [31:0] d, input logic [3:0] p);
        if (!port) begin
            bus.w0_valid_i = 1;
            bus.w0_addr_i  = 5'(a);
            bus.w0_data_i  = d;
            bus.w0_pos_i   = p;
        end else begin
            bus.w1_valid_i = 1;
            bus.w1_addr_i  = 5'(a);
            bus.w1_data_i  = d;
            bus.w1_pos_i   = p;
        end
        step();
    endtask

    // mode 0: ready high; 1: random ready; 2: 5-cycle stall at entry 7
    task automatic run_scan(input int mode);
        int d0, n, stall;
        d0 = done_cnt;
        stall = 0;
        bus.scan_start_i = 1;
        bus.out_ready_i  = 1;
        step();
        n = 0;
        while (done_cnt == d0 && n < 800) begin
            bus.out_ready_i = 1;
            if (mode == 1) bus.out_ready_i = 1'($urandom % 2);
            if (mode == 2 && bus.out_valid_o &&
                bus.out_addr_o == 5'd7 && stall < 5) begin
                bus.out_ready_i = 0;
                stall++;
                if (stall == 3) begin
                    bus.w1_valid_i = 1;
                    bus.w1_addr_i  = 5'd7;
                    bus.w1_data_i  = 32'hCAFE0007;
                    bus.w1_pos_i   = 4'h9;
                end
            end
            step();
            n++;
        end
        if (done_cnt == d0) begin
            chk("scan_timeout", 64'(done_cnt), 64'(d0 + 1));
        end else begin
            if (mode == 0)
                chk("scan_latency", 64'(done_cyc - start_cyc),
                    64'(exp_lat));
            if (mode == 2)
                chk("stall_latency", 64'(done_cyc - start_cyc),
                    64'(exp_lat + 5));
        end
        scanning = 0;
        chk("beats_left", 64'(bq.size()), 0);
        chk("idle_after", {bus.scan_busy_o, bus.scan_done_o}, 0);
        if (mode == 2) chk("stall_seen", 64'(stall), 5);
    endtask

    task automatic fill_low();
        for (int i = 0; i < 16; i++)
            wr(0, i, $urandom, 4'(1 + i % 15));
    endtask

    initial begin
        int b0, d0, n;
        bit pulsed;
        rst_n = 0;
        bus.w0_valid_i = 0; bus.w0_addr_i = '0;
        bus.w0_data_i  = '0; bus.w0_pos_i  = '0;
        bus.w1_valid_i = 0; bus.w1_addr_i = '0;
        bus.w1_data_i  = '0; bus.w1_pos_i  = '0;
        bus.scan_start_i = 0;
        bus.out_ready_i  = 0;
        do_reset();

        // fresh file: all zero (or all skipped)
        b0 = beat_cnt;
        run_scan(0);
`ifdef LAYER_REG_SKIP_EMPTY_EN
        chk("fresh_beats", 64'(beat_cnt - b0), 0);
`else
        chk("fresh_beats", 64'(beat_cnt - b0), 32);
`endif

        // both ports valid: grants alternate from port 0
        for (int i = 0; i < 4; i++) begin
            bus.w0_valid_i = 1; bus.w0_addr_i = 5'(16 + i);
            bus.w0_data_i = $urandom; bus.w0_pos_i = 4'(i + 1);
            bus.w1_valid_i = 1; bus.w1_addr_i = 5'(20 + i);
            bus.w1_data_i = $urandom; bus.w1_pos_i = 4'(i + 6);
            step();
        end

        wr(0, 3, 32'hDEADBEEF, 4'h5);
        step();

`ifdef LAYER_REG_SKIP_EMPTY_EN
        for (int i = 0; i < 32; i++) wr(0, i, 32'h0, 4'h0);
        wr(0, 2, 32'h1234_0002, 4'h3);
        wr(1, 30, 32'h1234_001E, 4'hA);
        b0 = beat_cnt;
        run_scan(0);
        chk("skip_beats", 64'(beat_cnt - b0), 2);
`else
        b0 = beat_cnt;
        run_scan(0);
        chk("full_beats", 64'(beat_cnt - b0), 32);
`endif

        fill_low();
        run_scan(2);

        for (int i = 0; i < 150; i++) begin
            bus.w0_valid_i = 1'($urandom % 2);
            bus.w0_addr_i = 5'($urandom_range(0, 31));
            bus.w0_data_i = $urandom; bus.w0_pos_i = 4'($urandom);
            bus.w1_valid_i = 1'($urandom % 2);
            bus.w1_addr_i = 5'($urandom_range(0, 31));
            bus.w1_data_i = $urandom; bus.w1_pos_i = 4'($urandom);
            bus.out_ready_i = 1'($urandom % 2);
            step();
        end
        run_scan(1);

        // ignored restart mid-scan, then reset at entry 10
        fill_low();
        bus.scan_start_i = 1;
        bus.out_ready_i  = 1;
        step();
        pulsed = 0;
        n = 0;
        while (!(bus.out_valid_o && bus.out_addr_o == 5'd10) && n < 200) begin
            bus.out_ready_i = 1;
            if (bus.out_valid_o && bus.out_addr_o == 5'd5 && !pulsed) begin
                bus.scan_start_i = 1;
                pulsed = 1;
            end
            step();
            n++;
        end
        chk("reached_entry10", {bus.out_valid_o, bus.out_addr_o},
            {1'b1, 5'd10});
        d0 = done_cnt;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            bus.out_ready_i = 1;
            step();
        end
        chk("no_done_after_reset", 64'(done_cnt), 64'(d0));
        chk("idle_after_reset", {bus.scan_busy_o, bus.out_valid_o}, 0);

        run_scan(0);
        step();
        step();
        chk("writes_left", 64'(wq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end
endmodule
